simmem_write_responder: RTL and testbench



---
 rtl/simmem_pkg.sv | 42 ++++
 rtl/simmem_aw_fifo.sv | 45 ++++
 rtl/simmem_write_responder.sv | 101 ++++++++++
 tb/tb_simmem_write_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared types and constants for the simmem write path.
// Optional build macro: SIMMEM_WLAST_CHECK_EN (enables W last-flag checking in the responder).
package simmem_pkg;

  localparam int unsigned IdWidth         = 4;
  localparam int unsigned AddrWidth       = 24;
  localparam int unsigned BurstLenWidth   = 8;
  localparam int unsigned BurstSizeWidth  = 3;
  localparam int unsigned DataWidth       = 12;
  localparam int unsigned StrbWidth       = 3;
  localparam int unsigned XRespWidth      = 2;
  localparam int unsigned RspPayloadWidth = 10;

  localparam logic [XRespWidth-1:0] XRespOkay   = 2'b00;
  localparam logic [XRespWidth-1:0] XRespSlvErr = 2'b10;

  localparam int unsigned WriteResponderAwQueueDepth = 4;

  typedef struct packed {
    logic [IdWidth-1:0]        id;
    logic [AddrWidth-1:0]      addr;
    logic [BurstLenWidth-1:0]  burst_length;
    logic [BurstSizeWidth-1:0] burst_size;
  } waddr_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } wdata_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]         id;
    logic [RspPayloadWidth-1:0] payload;
  } wresp_t;

  // Response payload: resp code in the low bits, upper bits zero.
  function automatic logic [RspPayloadWidth-1:0] make_payload(input logic [XRespWidth-1:0] resp);
    return {(RspPayloadWidth-XRespWidth)'(0), resp};
  endfunction

endpackage

// File: rtl/simmem_aw_fifo.sv
// Generic FIFO for buffering write address requests; Depth must be a power of 2.
module simmem_aw_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  logic [PtrWidth:0] wptr_q, rptr_q;
  logic [Width-1:0]  mem_q [Depth];
  logic              do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrWidth] != rptr_q[PtrWidth]) &&
                   (wptr_q[PtrWidth-1:0] == rptr_q[PtrWidth-1:0]);
  assign data_o  = mem_q[rptr_q[PtrWidth-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (PtrWidth+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (PtrWidth+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PtrWidth-1:0]] <= data_i;
  end

endmodule

// File: rtl/simmem_write_responder.sv
// Memory-side AXI write terminator: queues AW, discards W beats by count, returns one B per burst.
// Optional build macro: SIMMEM_WLAST_CHECK_EN flags last-flag mismatches as SLVERR.
module simmem_write_responder
  import simmem_pkg::*;
#(
  parameter int unsigned AwQueueDepth = WriteResponderAwQueueDepth
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  waddr_req_t waddr_i,
  input  logic       waddr_in_valid_i,
  output logic       waddr_in_ready_o,
  input  wdata_req_t wdata_i,
  input  logic       wdata_in_valid_i,
  output logic       wdata_in_ready_o,
  output wresp_t     wresp_o,
  output logic       wresp_out_valid_o,
  input  logic       wresp_out_ready_i
);

  logic                     aw_full, aw_empty, aw_push, aw_pop;
  waddr_req_t               aw_head;
  logic [BurstLenWidth-1:0] beat_cnt_q;
  logic                     w_hs, w_final;
  logic [XRespWidth-1:0]    resp_code;
  wresp_t                   wresp_q;
  logic                     wresp_valid_q;

  simmem_aw_fifo #(
    .Width($bits(waddr_req_t)),
    .Depth(AwQueueDepth)
  ) u_aw_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (aw_push),
    .data_i (waddr_i),
    .pop_i  (aw_pop),
    .full_o (aw_full),
    .empty_o(aw_empty),
    .data_o (aw_head)
  );

  assign waddr_in_ready_o = !aw_full;
  assign aw_push          = waddr_in_valid_i && !aw_full;

  // W is only taken when the B slot is free or draining this cycle.
  assign wdata_in_ready_o = !aw_empty && (!wresp_valid_q || wresp_out_ready_i);
  assign w_hs             = wdata_in_valid_i && wdata_in_ready_o;
  assign w_final          = (beat_cnt_q == aw_head.burst_length);
  assign aw_pop           = w_hs && w_final;

`ifdef SIMMEM_WLAST_CHECK_EN
  logic err_q, err_next;

  assign err_next  = err_q || (wdata_i.last != w_final);
  assign resp_code = err_next ? XRespSlvErr : XRespOkay;

  // Sticky per-burst error, cleared when the burst terminates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (w_hs) begin
      err_q <= w_final ? 1'b0 : err_next;
    end
  end

  logic unused_fields;
  assign unused_fields = ^{wdata_i.data, wdata_i.strb, aw_head.addr, aw_head.burst_size};
`else
  assign resp_code = XRespOkay;

  logic unused_fields;
  assign unused_fields = ^{wdata_i.data, wdata_i.strb, wdata_i.last,
                           aw_head.addr, aw_head.burst_size};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
    end else if (w_hs) begin
      beat_cnt_q <= w_final ? '0 : beat_cnt_q + BurstLenWidth'(1);
    end
  end

  // B register: a new final beat may reload it in the same cycle it is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wresp_q       <= '0;
      wresp_valid_q <= 1'b0;
    end else if (aw_pop) begin
      wresp_q       <= '{id: aw_head.id, payload: make_payload(resp_code)};
      wresp_valid_q <= 1'b1;
    end else if (wresp_out_ready_i) begin
      wresp_valid_q <= 1'b0;
    end
  end

  assign wresp_o           = wresp_q;
  assign wresp_out_valid_o = wresp_valid_q;

endmodule

// File: tb/tb_simmem_write_responder.sv
// Directed self-checking bench for simmem_write_responder.
module tb_simmem_write_responder;
  import simmem_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  waddr_req_t waddr;
  logic       waddr_valid;
  logic       waddr_ready;
  wdata_req_t wdata;
  logic       wdata_valid;
  logic       wdata_ready;
  wresp_t     wresp;
  logic       wresp_valid;
  logic       wresp_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [13:0] b_q[$];

  always #5 clk = ~clk;

  simmem_write_responder #(.AwQueueDepth(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .waddr_i          (waddr),
    .waddr_in_valid_i (waddr_valid),
    .waddr_in_ready_o (waddr_ready),
    .wdata_i          (wdata),
    .wdata_in_valid_i (wdata_valid),
    .wdata_in_ready_o (wdata_ready),
    .wresp_o          (wresp),
    .wresp_out_valid_o(wresp_valid),
    .wresp_out_ready_i(wresp_ready)
  );

  // Record B handshakes; inputs only change just after posedge, so negedge values hold through the edge.
  always @(negedge clk) begin
    if (rst_ni && wresp_valid && wresp_ready) b_q.push_back(wresp);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mk_b(input logic [3:0] id, input logic [1:0] resp);
    return {id, 8'd0, resp};
  endfunction

  task automatic send_aw(input logic [3:0] id, input logic [7:0] len);
    bit done = 0;
    waddr       = '{id: id, addr: 24'h1000 + 24'(id), burst_length: len, burst_size: 3'd2};
    waddr_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (waddr_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) check("aw_timeout", 32'd1, 32'd0);
    waddr_valid = 1'b0;
  endtask

  task automatic send_w(input logic last, output int stalls);
    bit done = 0;
    stalls      = 0;
    wdata       = '{data: 12'hA5A, strb: 3'b111, last: last};
    wdata_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (wdata_ready) begin
        @(posedge clk); #1;
        done = 1;
      end else begin
        stalls++;
      end
    end
    if (!done) check("w_timeout", 32'd1, 32'd0);
    wdata_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot;
    rst_ni      = 1'b0;
    waddr       = '0;
    waddr_valid = 1'b0;
    wdata       = '0;
    wdata_valid = 1'b0;
    wresp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_aw_ready", 32'(waddr_ready), 32'd1);
    check("rst_w_ready",  32'(wdata_ready), 32'd0);
    check("rst_b_valid",  32'(wresp_valid), 32'd0);
    check("rst_b_data",   32'(wresp),       32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // Single-beat burst, B one cycle after the W handshake
    send_aw(4'd3, 8'd0);
    send_w(1'b1, st);
    check("t1_b_valid", 32'(wresp_valid), 32'd1);
    check("t1_b_data",  32'(wresp), 32'(mk_b(4'd3, 2'b00)));

    // 256-beat burst
    send_aw(4'd5, 8'd255);
    tot = 0;
    for (int i = 0; i < 256; i++) begin
      send_w(i == 255, st);
      tot += st;
      if (i == 254) check("t2_b_early", 32'(wresp_valid), 32'd0);
    end
    check("t2_stalls",  32'(tot), 32'd0);
    check("t2_b_valid", 32'(wresp_valid), 32'd1);
    check("t2_b_data",  32'(wresp), 32'(mk_b(4'd5, 2'b00)));
    // Counter back at 0: a len=0 burst ends on its single beat
    send_aw(4'd6, 8'd0);
    send_w(1'b1, st);
    check("t2_cnt_reset", 32'(wresp), 32'(mk_b(4'd6, 2'b00)));
    check("t2_cnt_valid", 32'(wresp_valid), 32'd1);

    // Queue full and ordering
    @(posedge clk); #1;
    b_q.delete();
    for (int i = 1; i <= 4; i++) send_aw(4'(i), 8'd1);
    @(negedge clk);
    check("t3_full_ready", 32'(waddr_ready), 32'd0);
    @(posedge clk); #1;
    waddr       = '{id: 4'd5, addr: 24'h1005, burst_length: 8'd1, burst_size: 3'd2};
    waddr_valid = 1'b1;
    @(negedge clk);
    check("t3_full_hold", 32'(waddr_ready), 32'd0);
    @(posedge clk); #1;
    send_w(1'b0, st);
    send_w(1'b1, st);
    @(negedge clk);
    check("t3_after_pop", 32'(waddr_ready), 32'd1);
    @(posedge clk); #1;
    waddr_valid = 1'b0;
    @(negedge clk);
    check("t3_full_again", 32'(waddr_ready), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_w(i[0], st);
    repeat (3) @(posedge clk);
    #1;
    check("t3_b_count", 32'(b_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < b_q.size(); i++)
      check($sformatf("t3_b_order%0d", i), 32'(b_q[i]), 32'(mk_b(4'(i + 1), 2'b00)));

    // B backpressure stalls W; back-to-back B on reload
    wresp_ready = 1'b0;
    send_aw(4'd2, 8'd0);
    send_w(1'b1, st);
    check("t4_b1_data", 32'(wresp), 32'(mk_b(4'd2, 2'b00)));
    send_aw(4'd4, 8'd0);
    wdata_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_w_stall", 32'(wdata_ready), 32'd0);
      check("t4_b1_hold", 32'(wresp), 32'(mk_b(4'd2, 2'b00)));
    end
    @(posedge clk); #1;
    wresp_ready = 1'b1;
    @(negedge clk);
    check("t4_w_release", 32'(wdata_ready), 32'd1);
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    check("t4_b2_valid", 32'(wresp_valid), 32'd1);
    check("t4_b2_data",  32'(wresp), 32'(mk_b(4'd4, 2'b00)));
    @(posedge clk); #1;
    check("t4_b_drained", 32'(wresp_valid), 32'd0);

    // Asynchronous reset mid-burst with a full queue
    send_aw(4'd9, 8'd3);
    send_w(1'b0, st);
    send_w(1'b0, st);
    send_aw(4'd8, 8'd0);
    send_aw(4'd10, 8'd0);
    send_aw(4'd11, 8'd0);
    @(negedge clk);
    check("t5_pre_full", 32'(waddr_ready), 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    check("t5_aw_ready", 32'(waddr_ready), 32'd1);
    check("t5_w_ready",  32'(wdata_ready), 32'd0);
    check("t5_b_valid",  32'(wresp_valid), 32'd0);
    check("t5_b_data",   32'(wresp),       32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    send_aw(4'd7, 8'd0);
    send_w(1'b1, st);
    check("t5_b_valid_after", 32'(wresp_valid), 32'd1);
    check("t5_b_data_after",  32'(wresp), 32'(mk_b(4'd7, 2'b00)));

    // Last-flag mismatch: SLVERR only when checking is built in
    send_aw(4'd1, 8'd2);
    send_w(1'b0, st);
    send_w(1'b1, st);
    send_w(1'b0, st);
`ifdef SIMMEM_WLAST_CHECK_EN
    check("t6_bad_last", 32'(wresp), 32'(mk_b(4'd1, 2'b10)));
`else
    check("t6_bad_last", 32'(wresp), 32'(mk_b(4'd1, 2'b00)));
`endif
    send_aw(4'd12, 8'd1);
    send_w(1'b0, st);
    send_w(1'b1, st);
    check("t6_good_last", 32'(wresp), 32'(mk_b(4'd12, 2'b00)));

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
